// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // sll $0,$0,0 encodes as all zeros; used as the pipeline bubble
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
// Latency: count_o reflects an increment one cycle after inc_i is sampled.
// Backpressure: none; every sampled inc_i is counted until saturation.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Increment on request, hold once all ones so debug reads never wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage: PC register, next-PC select and the IF/ID pipeline latch.
// Latency: instr at pc_o appears on ifid_instr_o one cycle later; redirect lands on pc_o next cycle.
// Backpressure: pc_disenabler_i freezes the PC, ifid_disenabler_i freezes IF/ID; flush and redirect win.
module fetch_ifid_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_disenabler_i,
    input  logic             ifid_disenabler_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc_plus4_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] ifid_instr_q;
    logic [XLEN-1:0] ifid_pc_plus4_q;
    logic            ifid_valid_q;

    // Low target bits are forced to zero so the PC stays word-aligned
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target_i[1:0];

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 rolls to 0
    assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

    // PC update: redirect beats a PC hold, otherwise step sequentially
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= {redirect_target_i[31:2], 2'b00};
        end else if (!pc_disenabler_i) begin
            pc_q <= pc_plus4;
        end
    end

    // IF/ID latch: flush injects a bubble even while held, hold freezes all fields
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus4_q <= '0;
            ifid_valid_q    <= 1'b0;
        end else if (flush_i) begin
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_plus4_q <= pc_plus4;
            ifid_valid_q    <= 1'b0;
        end else if (!ifid_disenabler_i) begin
            ifid_instr_q    <= instr_i;
            ifid_pc_plus4_q <= pc_plus4;
            ifid_valid_q    <= 1'b1;
        end
    end

    // A flushed cycle is not counted as a stall, since the bubble replaces the held instr
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (ifid_disenabler_i & ~flush_i),
        .count_o (stall_count_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (flush_i),
        .count_o (flush_count_o)
    );

    assign pc_o            = pc_q;
    assign ifid_instr_o    = ifid_instr_q;
    assign ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign ifid_valid_o    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: default instance plus a wrap/saturation instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall/flush/redirect driven directly as directed steps.
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_dis;
    logic        ifid_dis;
    logic        flush;
    logic        redirect;
    logic [31:0] target;

    logic [31:0] a_instr, a_pc, a_ifid_instr, a_ifid_pc4;
    logic        a_valid;
    logic [15:0] a_stall, a_flush;

    logic [31:0] b_instr, b_pc, b_ifid_instr, b_ifid_pc4;
    logic        b_valid;
    logic [1:0]  b_stall, b_flush;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instruction memory model: data is a function of the fetch address
    assign a_instr = a_pc ^ 32'hA5A5_0000;
    assign b_instr = b_pc ^ 32'hA5A5_0000;

    fetch_ifid_stage dut_a (
        .clk               (clk),
        .reset             (reset),
        .pc_disenabler_i   (pc_dis),
        .ifid_disenabler_i (ifid_dis),
        .flush_i           (flush),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .instr_i           (a_instr),
        .pc_o              (a_pc),
        .ifid_instr_o      (a_ifid_instr),
        .ifid_pc_plus4_o   (a_ifid_pc4),
        .ifid_valid_o      (a_valid),
        .stall_count_o     (a_stall),
        .flush_count_o     (a_flush)
    );

    fetch_ifid_stage #(
        .RESET_PC (32'hFFFF_FFF8),
        .CNT_W    (2)
    ) dut_b (
        .clk               (clk),
        .reset             (reset),
        .pc_disenabler_i   (pc_dis),
        .ifid_disenabler_i (ifid_dis),
        .flush_i           (flush),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .instr_i           (b_instr),
        .pc_o              (b_pc),
        .ifid_instr_o      (b_ifid_instr),
        .ifid_pc_plus4_o   (b_ifid_pc4),
        .ifid_valid_o      (b_valid),
        .stall_count_o     (b_stall),
        .flush_count_o     (b_flush)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input logic pd, input logic id, input logic fl,
                       input logic rd, input logic [31:0] tg);
        pc_dis   = pd;
        ifid_dis = id;
        flush    = fl;
        redirect = rd;
        target   = tg;
    endtask

    initial begin
        reset = 1'b0;
        ctl(0, 0, 0, 0, 32'h0);
        step();
        step();

        // Reset state
        chk("rst_pc",     a_pc,         32'h0);
        chk("rst_instr",  a_ifid_instr, 32'h0);
        chk("rst_pc4",    a_ifid_pc4,   32'h0);
        chk("rst_valid",  {31'b0, a_valid}, 32'h0);
        chk("rst_stall",  {16'b0, a_stall}, 32'h0);
        chk("rst_flush",  {16'b0, a_flush}, 32'h0);

        // Free run
        reset = 1'b1;
        step();
        chk("run1_pc",    a_pc,         32'h4);
        chk("run1_valid", {31'b0, a_valid}, 32'h1);
        chk("run1_instr", a_ifid_instr, 32'hA5A5_0000);
        chk("run1_pc4",   a_ifid_pc4,   32'h4);
        step();
        chk("run2_pc",    a_pc,         32'h8);
        chk("run2_instr", a_ifid_instr, 32'hA5A5_0004);
        chk("run2_pc4",   a_ifid_pc4,   32'h8);

        // Load-use stall at pc=8
        ctl(1, 1, 0, 0, 32'h0);
        step();
        chk("lu_pc",      a_pc,         32'h8);
        chk("lu_instr",   a_ifid_instr, 32'hA5A5_0004);
        chk("lu_pc4",     a_ifid_pc4,   32'h8);
        chk("lu_stall",   {16'b0, a_stall}, 32'h1);
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("lu_rel_pc",    a_pc,         32'hC);
        chk("lu_rel_instr", a_ifid_instr, 32'hA5A5_0008);
        step();
        chk("pre_br_pc",    a_pc,         32'h10);
        chk("pre_br_instr", a_ifid_instr, 32'hA5A5_000C);

        // Branch at pc=0x10 with unaligned target
        ctl(0, 0, 1, 1, 32'h43);
        step();
        chk("br_pc",     a_pc,         32'h40);
        chk("br_instr",  a_ifid_instr, 32'h0);
        chk("br_valid",  {31'b0, a_valid}, 32'h0);
        chk("br_pc4",    a_ifid_pc4,   32'h14);
        chk("br_flush",  {16'b0, a_flush}, 32'h1);
        chk("br_stall",  {16'b0, a_stall}, 32'h1);
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("br_next_pc",    a_pc,         32'h44);
        chk("br_next_instr", a_ifid_instr, 32'hA5A5_0040);
        chk("br_next_valid", {31'b0, a_valid}, 32'h1);

        // Flush, stall and redirect all at once
        ctl(1, 1, 1, 1, 32'h100);
        step();
        chk("all_pc",    a_pc,         32'h100);
        chk("all_instr", a_ifid_instr, 32'h0);
        chk("all_valid", {31'b0, a_valid}, 32'h0);
        chk("all_stall", {16'b0, a_stall}, 32'h1);
        chk("all_flush", {16'b0, a_flush}, 32'h2);

        // PC held while IF/ID advances: same instr latched twice
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("mm_pc0",    a_pc,         32'h104);
        ctl(1, 0, 0, 0, 32'h0);
        step();
        chk("mm_pc1",    a_pc,         32'h104);
        chk("mm_instr1", a_ifid_instr, 32'hA5A5_0104);
        step();
        chk("mm_pc2",    a_pc,         32'h104);
        chk("mm_instr2", a_ifid_instr, 32'hA5A5_0104);
        chk("mm_pc4_2",  a_ifid_pc4,   32'h108);
        // IF/ID held while PC advances: fetched instr is lost
        ctl(0, 1, 0, 0, 32'h0);
        step();
        chk("mm_pc3",    a_pc,         32'h108);
        chk("mm_instr3", a_ifid_instr, 32'hA5A5_0104);
        chk("mm_stall3", {16'b0, a_stall}, 32'h2);
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("mm_instr4", a_ifid_instr, 32'hA5A5_0108);

        // Wrap instance: reset, then run across 2^32
        reset = 1'b0;
        step();
        chk("w_rst_pc",    b_pc, 32'hFFFF_FFF8);
        chk("w_rst_stall", {30'b0, b_stall}, 32'h0);
        reset = 1'b1;
        step();
        chk("w_pc1",  b_pc,       32'hFFFF_FFFC);
        chk("w_pc4_1", b_ifid_pc4, 32'hFFFF_FFFC);
        step();
        chk("w_pc2",  b_pc,       32'h0);
        chk("w_pc4_2", b_ifid_pc4, 32'h0);
        chk("w_instr2", b_ifid_instr, 32'h5A5A_FFFC);
        ctl(1, 1, 0, 0, 32'h0);
        step();
        chk("w_stall_pc", b_pc, 32'h0);
        chk("w_stall_cnt", {30'b0, b_stall}, 32'h1);

        // Reset mid-stall with a pending redirect
        reset = 1'b0;
        ctl(1, 1, 1, 1, 32'h200);
        step();
        chk("w_rr_pc",    b_pc,         32'hFFFF_FFF8);
        chk("w_rr_valid", {31'b0, b_valid}, 32'h0);
        chk("w_rr_instr", b_ifid_instr, 32'h0);
        chk("w_rr_pc4",   b_ifid_pc4,   32'h0);
        chk("w_rr_stall", {30'b0, b_stall}, 32'h0);
        chk("w_rr_flush", {30'b0, b_flush}, 32'h0);

        // Saturation with 2-bit counter: 1,2,3,3,3
        reset = 1'b1;
        ctl(1, 1, 0, 0, 32'h0);
        step();
        chk("sat1", {30'b0, b_stall}, 32'h1);
        step();
        chk("sat2", {30'b0, b_stall}, 32'h2);
        step();
        chk("sat3", {30'b0, b_stall}, 32'h3);
        step();
        chk("sat4", {30'b0, b_stall}, 32'h3);
        step();
        chk("sat5", {30'b0, b_stall}, 32'h3);
        chk("sat_pc", b_pc, 32'hFFFF_FFF8);
        chk("sat_flush", {30'b0, b_flush}, 32'h0);
        ctl(0, 0, 0, 0, 32'h0);
        step();
        chk("post_pc",    b_pc,         32'hFFFF_FFFC);
        chk("post_valid", {31'b0, b_valid}, 32'h1);
        chk("post_instr", b_ifid_instr, 32'h5A5A_FFF8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
